// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive front-end decoder.
package usb_rx_pkg;

  // Instantaneous classification of the differential pair.
  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2,
    LS_SE1 = 2'd3
  } line_state_t;

  // Decoder FSM states.
  typedef enum logic [1:0] {
    DATA  = 2'd0,
    STUFF = 2'd1,
    SE0   = 2'd2
  } rx_dec_state_t;

  localparam int unsigned STUFF_LEN_FS = 6;
  localparam int unsigned SE0_CNT_MAX  = 7;

  // Saturating increment for the SE0 run-length counter.
  function automatic logic [2:0] se0_cnt_inc(input logic [2:0] cnt);
    logic [2:0] res;
    if (cnt == 3'(SE0_CNT_MAX)) begin
      res = cnt;
    end else begin
      res = cnt + 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/usb_line_classify.sv
// Combinational J/K/SE0/SE1 classification of the D+/D- pair.
module usb_line_classify
  import usb_rx_pkg::*;
#(
  parameter int J_IS_DPLUS = 1
) (
  input  logic        d_plus,
  input  logic        d_minus,
  output line_state_t line_state
);

  localparam line_state_t DP_HIGH_LS = (J_IS_DPLUS != 0) ? LS_J : LS_K;
  localparam line_state_t DM_HIGH_LS = (J_IS_DPLUS != 0) ? LS_K : LS_J;

  // Map the two line levels onto a bus state for the selected speed.
  always_comb begin
    line_state = LS_SE1;
    case ({d_plus, d_minus})
      2'b00:   line_state = LS_SE0;
      2'b10:   line_state = DP_HIGH_LS;
      2'b01:   line_state = DM_HIGH_LS;
      2'b11:   line_state = LS_SE1;
      default: line_state = LS_SE1;
    endcase
  end

endmodule

// File: rtl/usb_rx_nrzi_unstuff.sv
// USB RX NRZI decoder with bit unstuffing and qualified EOP detection.
// One data bit per en_sample strobe; all outputs registered one clk later.
module usb_rx_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN   = STUFF_LEN_FS,
  parameter int EOP_SE0_MIN = 2,
  parameter int J_IS_DPLUS  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic en_sample,
  output logic rx_bit,
  output logic rx_bit_valid,
  output logic eop,
  output logic stuff_err,
  output logic line_err,
  output logic se0_active
);

  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STUFF = STUFF;
  localparam logic [1:0] ST_SE0   = SE0;

  localparam logic [3:0] STUFF_LEN_C = 4'(STUFF_LEN);
  localparam logic [2:0] EOP_MIN_C   = 3'(EOP_SE0_MIN);

  line_state_t line_s;

  logic [1:0] state_r, state_s;
  logic [1:0] resume_r, resume_s;   // DATA or STUFF to continue in after a glitch SE0
  logic [3:0] ones_cnt_r, ones_cnt_s;
  logic [2:0] se0_cnt_r, se0_cnt_s;
  logic       prev_k_r, prev_k_s;   // previous J/K level, 1 = K

  logic       is_k_s;
  logic       dec_s;
  logic       do_data_s;
  logic [1:0] eff_state_s;
  logic       bit_s, valid_s, eop_s, serr_s, lerr_s;

  usb_line_classify #(
    .J_IS_DPLUS(J_IS_DPLUS)
  ) u_classify (
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .line_state(line_s)
  );

  assign is_k_s = (line_s == LS_K);
  assign dec_s  = (is_k_s == prev_k_r);

  // Next-state, counter and pulse computation for one strobe.
  always_comb begin
    state_s     = state_r;
    resume_s    = resume_r;
    ones_cnt_s  = ones_cnt_r;
    se0_cnt_s   = se0_cnt_r;
    prev_k_s    = prev_k_r;
    bit_s       = 1'b0;
    valid_s     = 1'b0;
    eop_s       = 1'b0;
    serr_s      = 1'b0;
    lerr_s      = 1'b0;
    do_data_s   = 1'b0;
    eff_state_s = state_r;

    if (en_sample) begin
      case (line_s)
        LS_SE1: begin
          lerr_s = 1'b1;
        end
        LS_SE0: begin
          if (state_r != ST_SE0) begin
            resume_s = state_r;
          end else begin
            resume_s = resume_r;
          end
          state_s   = ST_SE0;
          se0_cnt_s = se0_cnt_inc(se0_cnt_r);
        end
        LS_J, LS_K: begin
          if (state_r == ST_SE0) begin
            se0_cnt_s = 3'd0;
            if (se0_cnt_r >= EOP_MIN_C) begin
              // Legal-length SE0: J completes an EOP, K is a line error.
              eop_s      = ~is_k_s;
              lerr_s     = is_k_s;
              prev_k_s   = is_k_s;
              ones_cnt_s = 4'd0;
              state_s    = ST_DATA;
            end else begin
              // Too short: forget the SE0 and decode this sample normally.
              do_data_s   = 1'b1;
              eff_state_s = resume_r;
            end
          end else begin
            do_data_s   = 1'b1;
            eff_state_s = state_r;
          end
        end
        default: begin
          lerr_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    if (do_data_s) begin
      prev_k_s = is_k_s;
      if (eff_state_s == ST_STUFF) begin
        serr_s     = dec_s;
        ones_cnt_s = 4'd0;
        state_s    = ST_DATA;
      end else begin
        bit_s   = dec_s;
        valid_s = 1'b1;
        if (dec_s) begin
          if ((ones_cnt_r + 4'd1) == STUFF_LEN_C) begin
            ones_cnt_s = 4'd0;
            state_s    = ST_STUFF;
          end else begin
            ones_cnt_s = ones_cnt_r + 4'd1;
            state_s    = ST_DATA;
          end
        end else begin
          ones_cnt_s = 4'd0;
          state_s    = ST_DATA;
        end
      end
    end else begin
      eff_state_s = state_r;
    end
  end

  // Decoder state and registered outputs; reset returns to idle-J.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_DATA;
      resume_r     <= ST_DATA;
      ones_cnt_r   <= 4'd0;
      se0_cnt_r    <= 3'd0;
      prev_k_r     <= 1'b0;
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
      eop          <= 1'b0;
      stuff_err    <= 1'b0;
      line_err     <= 1'b0;
      se0_active   <= 1'b0;
    end else begin
      state_r      <= state_s;
      resume_r     <= resume_s;
      ones_cnt_r   <= ones_cnt_s;
      se0_cnt_r    <= se0_cnt_s;
      prev_k_r     <= prev_k_s;
      rx_bit       <= bit_s;
      rx_bit_valid <= valid_s;
      eop          <= eop_s;
      stuff_err    <= serr_s;
      line_err     <= lerr_s;
      se0_active   <= (state_s == ST_SE0);
    end
  end

endmodule

// File: doc/usb_rx_nrzi_unstuff.md
Name: usb_rx_nrzi_unstuff

Overview:
Parametrised successor to the USB RX front-end decoder. It samples the differential pair on en_sample strobes and performs NRZI decoding, bit unstuffing, and qualified EOP detection (SE0 for a minimum number of samples, then J). It also flags stuff errors and line errors. It sits between the RX edge-sync/sample-timing logic and the RX shift register/packet FSM, and delivers one valid data bit per strobe with stuffed bits removed.

Parameters:
STUFF_LEN, 6, number of consecutive decoded 1s after which the next bit must be a stuffed 0 (range 2..15)
EOP_SE0_MIN, 2, minimum consecutive SE0 samples for a legal EOP (range 1..7)
J_IS_DPLUS, 1, 1 = full-speed (J: d_plus=1, d_minus=0); 0 = low-speed (J: d_plus=0, d_minus=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
d_plus  in  1  synchronised D+ line
d_minus  in  1  synchronised D- line
en_sample  in  1  one-cycle strobe at bit centre; all inputs are ignored unless it is high
rx_bit  out  1  decoded, unstuffed data bit; valid only with rx_bit_valid
rx_bit_valid  out  1  one-cycle pulse; rx_bit is a real data bit
eop  out  1  one-cycle pulse; a legal EOP has completed
stuff_err  out  1  one-cycle pulse; a stuffed-bit position carried a 1
line_err  out  1  one-cycle pulse; SE1 was sampled, or a legal-length SE0 ended in K
se0_active  out  1  level; high while the FSM is in SE0

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: all outputs 0; prev_lvl = J; ones_cnt = 0; se0_cnt = 0; FSM in DATA.
- Line classification is combinational: J, K, SE0 (both low) or SE1 (both high), per J_IS_DPLUS.
- All outputs are registered. Each output reflects the en_sample cycle one clk earlier.
- Pulse outputs last exactly one clk.
- If en_sample is low, no state changes and all pulse outputs are 0.
- Decoding rule: dec = 1 when the sampled level (J/K) equals prev_lvl, else 0. prev_lvl updates on every J/K sample.
- FSM states: DATA, STUFF, SE0.
- DATA, J/K sample:
  - rx_bit = dec, rx_bit_valid = 1.
  - dec = 1: ones_cnt++. When ones_cnt reaches STUFF_LEN, clear it and go to STUFF.
  - dec = 0: ones_cnt = 0.
- STUFF, J/K sample: the bit is always dropped (rx_bit_valid = 0), ones_cnt = 0, return to DATA.
  - dec = 1: stuff_err pulse.
  - Stuffing is checked again from a fresh count after this bit.
- Any state, SE0 sample:
  - Go to SE0; se0_cnt++, saturating at 7.
  - No data valid; prev_lvl unchanged.
  - ones_cnt is preserved, and so is a pending STUFF (the state to resume is remembered).
- SE0, J sample:
  - se0_cnt >= EOP_SE0_MIN: eop pulse, prev_lvl = J, ones_cnt = 0, state DATA.
  - se0_cnt < EOP_SE0_MIN (glitch): discard the SE0 and process the J as a normal data sample in the resumed state (DATA or STUFF).
  - In both cases se0_cnt = 0.
- SE0, K sample:
  - Legal length: line_err pulse, prev_lvl = K, ones_cnt = 0, state DATA, no data valid.
  - Short: treated as a glitch, same as the short-J case.
- SE1 in any state: line_err pulse, sample ignored, state and counters unchanged.
- Counter widths: ones_cnt is 4 bits; se0_cnt is 3 bits.
- Simultaneous rst and en_sample: rst wins.
- Reset mid-packet: returns to the reset state; the next bit is decoded against J.

Decomposition:
- Package usb_rx_pkg:
  - enum line_state_t {LS_J, LS_K, LS_SE0, LS_SE1}
  - enum rx_dec_state_t {DATA, STUFF, SE0}
  - constants STUFF_LEN_FS = 6 and SE0_CNT_MAX = 7
- Sub-module usb_line_classify: combinational; inputs d_plus, d_minus; output line_state_t; parameter J_IS_DPLUS.
- The FSM and counters live in the top module.

Test Plan:
- Reset then sample pattern K,K,J,J,K (FS): rx_bit = 0,1,0,1,0 with 5 rx_bit_valid pulses, each one clk after its strobe; no error pulses.
- Six consecutive same-level samples followed by a toggle: six 1s valid, the toggle dropped (no valid, no stuff_err), then the next bit is decoded normally.
- Seven consecutive same-level samples: six 1s valid, stuff_err pulse on the 7th with no valid; the 8th bit is decoded from a fresh count.
- SE0, SE0, J (EOP_SE0_MIN = 2): se0_active high for 2 clk-samples, eop pulse on the J; the next K decodes as 0.
- Single SE0 then J after prev_lvl = J: no eop, rx_bit = 1 valid (glitch filtered). Separately, SE1 sample: line_err pulse, no valid, the next bit is decoded against the unchanged prev_lvl.
- SE0, SE0, K: line_err pulse, no eop. Also assert rst mid-byte: all outputs 0 the next clk and the following K decodes as 0.
